// File: rtl/read_iq_pkg.sv
// Shared constants, FSM state encoding and the dequantize helper for read_iq.
package read_iq_pkg;

  localparam int BYTE_WIDTH   = 8;
  localparam int SAMPLE_WIDTH = 16;
  localparam int DATA_WIDTH   = 32;
  localparam int QUANT_BITS   = 10;

  // One state per byte slot of a sample, then one state to push the pair.
  typedef enum logic [2:0] {
    S_I_LO,
    S_I_HI,
    S_Q_LO,
    S_Q_HI,
    S_WRITE
  } state_t;

  // Sign-extend a raw component to the output width, then scale it up.
  // With 16 + 10 <= 32 the shift never loses significant bits.
  function automatic logic signed [DATA_WIDTH-1:0] dequantize(
    input logic [SAMPLE_WIDTH-1:0] raw
  );
    logic signed [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-SAMPLE_WIDTH){raw[SAMPLE_WIDTH-1]}}, raw};
    return ext <<< QUANT_BITS;
  endfunction

endpackage

// File: rtl/read_iq.sv
// Byte-stream to complex-sample assembler feeding the FIR input FIFO.
// Pops I_lo, I_hi, Q_lo, Q_hi from a FWFT byte FIFO, dequantizes both
// components and writes the {I,Q} pair downstream in a dedicated state.
module read_iq
  import read_iq_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BYTE_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  out_wr_en,
  input  logic                  out_full
);

  state_t                state;
  logic [BYTE_WIDTH-1:0] i_lo;
  logic [BYTE_WIDTH-1:0] i_hi;
  logic [BYTE_WIDTH-1:0] q_lo;
  logic                  reading;

  // Pop only in the byte states and push only in S_WRITE; both strobes are
  // forced low while reset is held so nothing moves during reset.
  always_comb begin
    reading   = (state != S_WRITE);
    in_rd_en  = reset & reading & ~in_empty;
    out_wr_en = reset & (state == S_WRITE) & ~out_full;
  end

  // Sequencer and datapath: capture each byte into its slot, form the
  // dequantized pair on the Q_hi edge, and hold it until the push happens.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_I_LO;
      i_lo  <= '0;
      i_hi  <= '0;
      q_lo  <= '0;
      i_out <= '0;
      q_out <= '0;
    end else begin
      case (state)
        S_I_LO: begin
          if (in_rd_en) begin
            i_lo  <= in_dout;
            state <= S_I_HI;
          end
        end
        S_I_HI: begin
          if (in_rd_en) begin
            i_hi  <= in_dout;
            state <= S_Q_LO;
          end
        end
        S_Q_LO: begin
          if (in_rd_en) begin
            q_lo  <= in_dout;
            state <= S_Q_HI;
          end
        end
        S_Q_HI: begin
          // Q_hi is used straight from the FIFO so the pair is ready on
          // the very edge that completes the sample.
          if (in_rd_en) begin
            i_out <= dequantize({i_hi, i_lo});
            q_out <= dequantize({in_dout, q_lo});
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (out_wr_en) begin
            state <= S_I_LO;
          end
        end
        default: state <= S_I_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_read_iq.sv
// Directed self-checking bench for read_iq: reset, basic assembly, extremes,
// backpressure, reset mid-sample, upstream bubbles and throughput.
module tb_read_iq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_dout = 8'h00;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] i_out;
  logic [31:0] q_out;
  logic        out_wr_en;
  logic        out_full = 1'b0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rd_first = -1;
  int wr_last = -1;
  int wr_count = 0;
  logic [63:0] wr_q[$];

  read_iq dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_wr_en (out_wr_en),
    .out_full  (out_full)
  );

  always #5 clock = ~clock;

  // Observe strobes on the falling edge: record pushes and pop timing.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (in_rd_en && rd_first < 0) rd_first = cyc;
    if (out_wr_en) begin
      wr_q.push_back({i_out, q_out});
      wr_count = wr_count + 1;
      wr_last  = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference: signed 16-bit value times 2^10.
  function automatic logic [31:0] deq(input logic [15:0] x);
    int v;
    v = $signed(x);
    return v * 1024;
  endfunction

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clock);
    #1;
  endtask

  // Present one byte after 'gap' empty cycles and wait until it is popped.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic popped;
    popped = 1'b0;
    in_empty = 1'b1;
    repeat (gap) align();
    in_dout  = b;
    in_empty = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      popped = in_rd_en;
      align();
      if (popped) begin
        in_empty = 1'b1;
        return;
      end
    end
    check("pop_timeout", {63'd0, popped}, 64'd1);
    in_empty = 1'b1;
  endtask

  task automatic send_sample(input logic [15:0] i, input logic [15:0] q, input int gap);
    send_byte(i[7:0], gap);
    send_byte(i[15:8], gap);
    send_byte(q[7:0], gap);
    send_byte(q[15:8], gap);
  endtask

  // Wait (bounded) for one captured push and compare it.
  task automatic expect_sample(input string tag, input logic [31:0] ei, input logic [31:0] eq);
    logic [63:0] v;
    for (int n = 0; n < 50 && wr_q.size() == 0; n++) at_sample();
    if (wr_q.size() == 0) begin
      check({tag, "_timeout"}, 64'(wr_q.size()), 64'd1);
    end else begin
      v = wr_q.pop_front();
      $display("sample %s i=%h q=%h", tag, v[63:32], v[31:0]);
      check({tag, "_i"}, {32'd0, v[63:32]}, {32'd0, ei});
      check({tag, "_q"}, {32'd0, v[31:0]}, {32'd0, eq});
    end
    align();
  endtask

  initial begin
    logic [15:0] ri;
    logic [15:0] rq;
    logic [63:0] exp_q[$];
    logic [63:0] v;

    // Reset state, with data offered upstream to prove the pop is gated.
    reset    = 1'b0;
    in_dout  = 8'h5A;
    in_empty = 1'b0;
    at_sample();
    check("rst_rd_en", {63'd0, in_rd_en}, 64'd0);
    check("rst_wr_en", {63'd0, out_wr_en}, 64'd0);
    check("rst_i_out", {32'd0, i_out}, 64'd0);
    check("rst_q_out", {32'd0, q_out}, 64'd0);
    in_empty = 1'b1;
    align();
    reset = 1'b1;
    align();

    // Basic assembly and latency.
    rd_first = -1;
    wr_count = 0;
    send_sample(16'h1234, 16'h5678, 0);
    expect_sample("basic", 32'h0048D000, 32'h0159E000);
    repeat (5) at_sample();
    check("basic_count", 64'(wr_count), 64'd1);
    check("basic_latency", 64'(wr_last - rd_first), 64'd4);
    align();

    // Sign extension extremes.
    send_sample(16'hFFFF, 16'h8000, 0);
    expect_sample("neg", 32'hFFFFFC00, 32'hFE000000);
    send_sample(16'h7FFF, 16'h0000, 0);
    expect_sample("max", 32'h01FFFC00, 32'h00000000);

    // Downstream backpressure held across seven sample points in S_WRITE.
    out_full = 1'b1;
    send_sample(16'h2211, 16'h4433, 0);
    in_dout  = 8'hEE;
    in_empty = 1'b0;
    for (int n = 0; n < 7; n++) begin
      at_sample();
      check("bp_wr_en", {63'd0, out_wr_en}, 64'd0);
      check("bp_rd_en", {63'd0, in_rd_en}, 64'd0);
      check("bp_iq", {i_out, q_out}, {32'h00884400, 32'h0110CC00});
    end
    align();
    out_full = 1'b0;
    in_empty = 1'b1;
    at_sample();
    check("bp_release", {63'd0, out_wr_en}, 64'd1);
    expect_sample("bp", 32'h00884400, 32'h0110CC00);

    // Reset mid-sample after I_lo and I_hi were popped.
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    reset    = 1'b0;
    in_dout  = 8'h77;
    in_empty = 1'b0;
    at_sample();
    check("mid_rst_rd_en", {63'd0, in_rd_en}, 64'd0);
    check("mid_rst_wr_en", {63'd0, out_wr_en}, 64'd0);
    check("mid_rst_iq", {i_out, q_out}, 64'd0);
    in_empty = 1'b1;
    align();
    reset = 1'b1;
    align();
    send_sample(16'h0001, 16'h0002, 0);
    expect_sample("after_rst", 32'h00000400, 32'h00000800);

    // Upstream bubbles of random length between every byte.
    for (int k = 0; k < 24; k++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      send_byte(ri[7:0], int'($urandom_range(0, 3)));
      send_byte(ri[15:8], int'($urandom_range(0, 3)));
      send_byte(rq[7:0], int'($urandom_range(0, 3)));
      send_byte(rq[15:8], int'($urandom_range(0, 3)));
      expect_sample("bubble", deq(ri), deq(rq));
    end

    // Throughput: 1000 back-to-back samples.
    wr_q.delete();
    rd_first = -1;
    wr_count = 0;
    for (int k = 0; k < 1000; k++) begin
      ri = 16'(k * 37 + 5);
      rq = 16'(16'hFFFF - k * 11);
      exp_q.push_back({deq(ri), deq(rq)});
      send_sample(ri, rq, 0);
    end
    repeat (6) at_sample();
    check("thru_count", 64'(wr_count), 64'd1000);
    check("thru_cycles", 64'(wr_last - rd_first + 1), 64'd5000);
    check("thru_depth", 64'(wr_q.size()), 64'(exp_q.size()));
    while (wr_q.size() > 0 && exp_q.size() > 0) begin
      v = wr_q.pop_front();
      check("thru_data", v, exp_q.pop_front());
    end
    $display("throughput samples=%0d cycles=%0d", wr_count, wr_last - rd_first + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_iq.md
Name: read_iq

Overview:
- Front-end producer for the complex FIR stage.
- Consumes the raw little-endian 16-bit I/Q byte stream from an upstream byte FIFO and assembles one sample from I_lo, I_hi, Q_lo, Q_hi.
- Dequantizes each component to 32-bit signed fixed point and pushes the {I,Q} pair into the FIR's input FIFO.
- It is the write side of the interface the FIR input FIFO reads: i_out and q_out land at fifo din[63:32] and din[31:0].

Parameters:
- BYTE_WIDTH, 8: upstream FIFO data width.
- SAMPLE_WIDTH, 16: raw I/Q component width; two bytes, little-endian.
- DATA_WIDTH, 32: output component width.
- QUANT_BITS, 10: left-shift applied after sign extension (dequantize).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_dout  in  8  byte from upstream first-word-fall-through (FWFT) FIFO; valid whenever in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop upstream byte this cycle.
- i_out  out  32  dequantized I; connects to FIR fifo din[63:32].
- q_out  out  32  dequantized Q; connects to FIR fifo din[31:0].
- out_wr_en  out  1  push {i_out,q_out} this cycle.
- out_full  in  1  downstream FIFO full.

Behaviour:
- Reset is asynchronous, active-low. While reset=0:
  - state=S_I_LO; I/Q byte registers=0; i_out=q_out=0.
  - in_rd_en=0; out_wr_en=0.
- FSM states: S_I_LO, S_I_HI, S_Q_LO, S_Q_HI, S_WRITE.
- Read states (S_I_LO through S_Q_HI):
  - in_rd_en = ~in_empty, combinational.
  - On a rising edge with in_rd_en=1: capture in_dout into the byte slot for the current state and advance to the next state.
  - With in_empty=1: hold state; no capture.
- S_Q_HI → S_WRITE edge: i_out and q_out are registered in the same edge as Q_hi is captured.
  - i_out = sext32({I_hi,I_lo}) <<< QUANT_BITS, truncated to 32 bits.
  - q_out = sext32({Q_hi,Q_lo}) <<< QUANT_BITS, truncated to 32 bits.
- S_WRITE:
  - out_wr_en = ~out_full, combinational; in_rd_en=0.
  - When out_wr_en=1, go to S_I_LO on the next edge.
  - When out_full=1, hold S_WRITE with i_out/q_out stable until space is available.
- i_out/q_out hold their last value outside S_WRITE and are never X after reset.
- Throughput: best case one sample per 5 cycles. Latency from first byte popped to out_wr_en is 4 cycles, with no stalls.
- Stalls:
  - in_empty mid-sample: partial bytes are retained and the sample resumes where it stopped; no bytes are dropped or reordered.
  - out_full while in S_WRITE: upstream is not popped during the stall.
- Boundaries:
  - Most negative: 0x8000 → 0xFE000000.
  - Max: 0x7FFF → 0x01FFFC00.
  - -1: 0xFFFF → 0xFFFFFC00.
  - No saturation is needed at the default settings: 16+10 ≤ 32.
- Reset asserted mid-sample: the partial sample is discarded and the FSM returns to S_I_LO. After release, the next byte is treated as I_lo.
- No simultaneous read and write: the FSM is exclusive by state.

Decomposition:
- Shared package read_iq_pkg:
  - Constants BYTE_WIDTH, SAMPLE_WIDTH, DATA_WIDTH, QUANT_BITS.
  - State enum state_t.
  - Function dequantize(logic [15:0]) returning logic signed [31:0].
- No sub-module: a single FSM plus datapath registers.
- The top-level wrapper instantiates the existing byte FIFO, read_iq and the FIR input FIFO.

Test Plan:
- Basic: bytes 34 12 78 56, never empty or full → exactly one out_wr_en pulse with i_out=0x0048D000, q_out=0x0159E000, 4 cycles after the first pop.
- Sign/extremes: FF FF 00 80 → i_out=0xFFFFFC00, q_out=0xFE000000. Then FF 7F 00 00 → i_out=0x01FFFC00, q_out=0x00000000.
- Upstream bubbles: in_empty toggled randomly over the 200000 samples of the IQ input file → output stream identical to the golden 64-bit hex file (%16h, {I,Q}), 0 errors.
- Downstream backpressure: out_full held high for 7 cycles in S_WRITE → out_wr_en=0 and in_rd_en=0 throughout, i_out/q_out stable. The sample is written on the first cycle after out_full falls.
- Reset mid-sample: reset=0 after the I_lo and I_hi bytes are popped. After release, feed 01 00 02 00 → i_out=0x00000400, q_out=0x00000800. All outputs are 0 during reset.
- Throughput: 1000 samples with no stalls → exactly 5000 cycles from the first in_rd_en to the last out_wr_en+1; out_wr_en pulse count = 1000.
